// File: rtl/mulberry_rr_sched.sv
// Round-robin request scheduler for the mulberry bus: grants at most one slave-eligible
// master per cycle and caps the in-flight requests per slave.
module mulberry_rr_sched #(
  parameter int N_MST      = 2,
  parameter int N_SLV      = 3,
  parameter int SID_W      = 2,
  parameter int MID_W      = 2,
  parameter int DATA_W     = 32,
  parameter int MAX_OUTSTD = 2
) (
  input  logic                    clk_ir,
  input  logic                    rst_il,
  input  logic [N_MST*SID_W-1:0]  mst_sid_i,
  input  logic [N_MST*DATA_W-1:0] mst_data_i,
  output logic [N_MST-1:0]        mst_gnt_o,
  input  logic [N_SLV-1:0]        slv_busy_i,
  output logic [N_SLV*MID_W-1:0]  slv_req_mid_o,
  output logic [DATA_W-1:0]       slv_req_data_o,
  input  logic [N_SLV-1:0]        slv_rsp_vld_i,
  output logic                    err_sid_o,
  output logic                    err_rsp_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTD + 1);
  localparam int PTR_W = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTD);

  logic [N_MST-1:0]       gnt_q, gnt_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [N_SLV*MID_W-1:0] mid_q, mid_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [CNT_W-1:0]       outstd_q [N_SLV];
  logic [CNT_W-1:0]       outstd_d [N_SLV];
  logic                   err_sid_q, err_sid_d;
  logic                   err_rsp_q, err_rsp_d;

  logic [N_MST-1:0] elig, illegal;
  logic [N_SLV-1:0] issue;
  logic [SID_W-1:0] sid, win_sid;
  logic             slv_ok, win_vld;
  int               win, cand;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    elig    = '0;
    illegal = '0;
    sid     = '0;
    slv_ok  = 1'b0;
    for (int m = 0; m < N_MST; m++) begin
      sid    = mst_sid_i[m*SID_W +: SID_W];
      slv_ok = 1'b0;
      for (int s = 0; s < N_SLV; s++) begin
        if (sid == SID_W'(s + 1)) slv_ok = !slv_busy_i[s] && (outstd_q[s] < CNT_MAX);
      end
      // A master granted last cycle still shows its old request, so it sits out one cycle.
      elig[m]    = slv_ok && !gnt_q[m];
      illegal[m] = (sid != '0) && (int'(sid) > N_SLV);
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win     = 0;
    cand    = 0;
    for (int k = 0; k < N_MST; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_MST) cand = cand - N_MST;
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end

    gnt_d   = '0;
    mid_d   = '0;
    data_d  = data_q;
    ptr_d   = ptr_q;
    issue   = '0;
    win_sid = '0;
    if (win_vld) begin
      win_sid    = mst_sid_i[win*SID_W +: SID_W];
      gnt_d[win] = 1'b1;
      data_d     = mst_data_i[win*DATA_W +: DATA_W];
      ptr_d      = (win == N_MST - 1) ? '0 : PTR_W'(win + 1);
      for (int s = 0; s < N_SLV; s++) begin
        if (win_sid == SID_W'(s + 1)) begin
          issue[s]                = 1'b1;
          mid_d[s*MID_W +: MID_W] = MID_W'(win + 1);
        end
      end
    end
  end

  always_comb begin
    err_sid_d = err_sid_q | (|illegal);
    err_rsp_d = err_rsp_q;
    for (int s = 0; s < N_SLV; s++) begin
      outstd_d[s] = outstd_q[s];
      if (issue[s] && !slv_rsp_vld_i[s]) begin
        outstd_d[s] = outstd_q[s] + CNT_W'(1);
      end else if (!issue[s] && slv_rsp_vld_i[s]) begin
        if (outstd_q[s] == '0) err_rsp_d = 1'b1;
        else                   outstd_d[s] = outstd_q[s] - CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      gnt_q     <= '0;
      ptr_q     <= '0;
      mid_q     <= '0;
      data_q    <= '0;
      err_sid_q <= 1'b0;
      err_rsp_q <= 1'b0;
      // NOTE: the counter array is reset deliberately; stale counts would block or mis-flag slaves.
      for (int s = 0; s < N_SLV; s++) outstd_q[s] <= '0;
    end else begin
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      mid_q     <= mid_d;
      data_q    <= data_d;
      err_sid_q <= err_sid_d;
      err_rsp_q <= err_rsp_d;
      for (int s = 0; s < N_SLV; s++) outstd_q[s] <= outstd_d[s];
    end
  end

  assign mst_gnt_o      = gnt_q;
  assign slv_req_mid_o  = mid_q;
  assign slv_req_data_o = data_q;
  assign err_sid_o      = err_sid_q;
  assign err_rsp_o      = err_rsp_q;

endmodule

// File: tb/tb_mulberry_rr_sched.sv
// Bench for mulberry_rr_sched: a cycle-level reference model checked every clock, directed
// scenarios with literal expectations, and a randomized traffic phase.
module tb_mulberry_rr_sched;

  localparam int N_MST      = 2;
  localparam int N_SLV      = 3;
  localparam int N_SLV2     = 2;
  localparam int SID_W      = 2;
  localparam int MID_W      = 2;
  localparam int DATA_W     = 32;
  localparam int MAX_OUTSTD = 2;

  logic clk_ir = 1'b0;
  logic rst_il = 1'b1;

  logic [N_MST*SID_W-1:0]  mst_sid_i     = '0;
  logic [N_MST*DATA_W-1:0] mst_data_i    = '0;
  logic [N_MST-1:0]        mst_gnt_o;
  logic [N_SLV-1:0]        slv_busy_i    = '0;
  logic [N_SLV*MID_W-1:0]  slv_req_mid_o;
  logic [DATA_W-1:0]       slv_req_data_o;
  logic [N_SLV-1:0]        slv_rsp_vld_i = '0;
  logic                    err_sid_o, err_rsp_o;

  // Second instance with only two slaves, so SID 3 is illegal there.
  logic [N_MST*SID_W-1:0]  sid2   = '0;
  logic [N_MST*DATA_W-1:0] data2  = '0;
  logic [N_MST-1:0]        gnt2;
  logic [N_SLV2-1:0]       busy2  = '0;
  logic [N_SLV2*MID_W-1:0] mid2;
  logic [DATA_W-1:0]       dout2;
  logic [N_SLV2-1:0]       rsp2   = '0;
  logic                    esid2, ersp2;

  mulberry_rr_sched #(.N_MST(N_MST), .N_SLV(N_SLV), .SID_W(SID_W), .MID_W(MID_W),
                      .DATA_W(DATA_W), .MAX_OUTSTD(MAX_OUTSTD)) dut (
    .clk_ir(clk_ir), .rst_il(rst_il),
    .mst_sid_i(mst_sid_i), .mst_data_i(mst_data_i), .mst_gnt_o(mst_gnt_o),
    .slv_busy_i(slv_busy_i), .slv_req_mid_o(slv_req_mid_o), .slv_req_data_o(slv_req_data_o),
    .slv_rsp_vld_i(slv_rsp_vld_i), .err_sid_o(err_sid_o), .err_rsp_o(err_rsp_o)
  );

  mulberry_rr_sched #(.N_MST(N_MST), .N_SLV(N_SLV2), .SID_W(SID_W), .MID_W(MID_W),
                      .DATA_W(DATA_W), .MAX_OUTSTD(MAX_OUTSTD)) dut2 (
    .clk_ir(clk_ir), .rst_il(rst_il),
    .mst_sid_i(sid2), .mst_data_i(data2), .mst_gnt_o(gnt2),
    .slv_busy_i(busy2), .slv_req_mid_o(mid2), .slv_req_data_o(dout2),
    .slv_rsp_vld_i(rsp2), .err_sid_o(esid2), .err_rsp_o(ersp2)
  );

  always #5 clk_ir = ~clk_ir;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: round-robin pointer, per-slave in-flight counts, last granted master.
  int                     m_ptr, m_last;
  int                     m_out [N_SLV];
  bit                     m_esid, m_ersp;
  logic [N_MST-1:0]       e_gnt;
  logic [N_SLV*MID_W-1:0] e_mid;
  logic [DATA_W-1:0]      e_data;

  task automatic model_reset();
    m_ptr  = 0;
    m_last = -1;
    for (int s = 0; s < N_SLV; s++) m_out[s] = 0;
    m_esid = 0;
    m_ersp = 0;
    e_gnt  = '0;
    e_mid  = '0;
    e_data = '0;
  endtask

  task automatic model_step();
    int sid [N_MST];
    int win;
    int m;
    bit iss;
    win = -1;
    for (int i = 0; i < N_MST; i++) sid[i] = int'(mst_sid_i[i*SID_W +: SID_W]);
    for (int k = 0; k < N_MST; k++) begin
      m = (m_ptr + k) % N_MST;
      if (win < 0 && m != m_last && sid[m] >= 1 && sid[m] <= N_SLV) begin
        if (!slv_busy_i[sid[m]-1] && m_out[sid[m]-1] < MAX_OUTSTD) win = m;
      end
    end
    for (int i = 0; i < N_MST; i++) if (sid[i] > N_SLV) m_esid = 1;
    for (int s = 0; s < N_SLV; s++) begin
      iss = 0;
      if (win >= 0) iss = (sid[win] == s + 1);
      if (iss && !slv_rsp_vld_i[s]) m_out[s]++;
      else if (!iss && slv_rsp_vld_i[s]) begin
        if (m_out[s] == 0) m_ersp = 1;
        else m_out[s]--;
      end
    end
    e_gnt = '0;
    e_mid = '0;
    if (win >= 0) begin
      e_gnt[win] = 1'b1;
      e_mid[(sid[win]-1)*MID_W +: MID_W] = MID_W'(win + 1);
      e_data = mst_data_i[win*DATA_W +: DATA_W];
      m_ptr  = (win + 1) % N_MST;
    end
    m_last = win;
  endtask

  always @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) model_reset();
    else         model_step();
    #1;
    check("gnt",     mst_gnt_o,      e_gnt);
    check("req_mid", slv_req_mid_o,  e_mid);
    check("data",    slv_req_data_o, e_data);
    check("err_sid", err_sid_o,      m_esid);
    check("err_rsp", err_rsp_o,      m_ersp);
  end

  logic [SID_W-1:0] nxt_sid [N_MST];

  task automatic set_req(input int m, input int sid);
    mst_sid_i[m*SID_W +: SID_W]   = SID_W'(sid);
    mst_data_i[m*DATA_W +: DATA_W] = $urandom();
  endtask

  // One clock as seen by well-behaved masters and, optionally, slaves that answer every strobe.
  task automatic cyc(input bit auto_rsp);
    @(negedge clk_ir);
    for (int m = 0; m < N_MST; m++) if (mst_gnt_o[m]) set_req(m, int'(nxt_sid[m]));
    for (int s = 0; s < N_SLV; s++)
      slv_rsp_vld_i[s] = auto_rsp && (slv_req_mid_o[s*MID_W +: MID_W] != '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    bit found;

    #1 rst_il = 1'b0;
    #2;
    check("rst_gnt", mst_gnt_o, '0);
    check("rst_mid", slv_req_mid_o, '0);
    @(negedge clk_ir);
    @(negedge clk_ir);
    rst_il = 1'b1;

    // Two masters contending for SID 1 alternate, starting at m0.
    nxt_sid[0] = 2'd1; nxt_sid[1] = 2'd1;
    set_req(0, 1); set_req(1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      check("t1_gnt", mst_gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("t1_mid0", slv_req_mid_o[MID_W-1:0], (i % 2 == 0) ? 2'd1 : 2'd2);
    end
    nxt_sid[0] = '0; nxt_sid[1] = '0;
    set_req(0, 0); set_req(1, 0);
    repeat (3) cyc(1'b1);

    // Busy slave 2 holds m0 back; m1 on free slave 3 gets every other cycle.
    slv_busy_i = 3'b010;
    nxt_sid[0] = 2'd2; nxt_sid[1] = 2'd3;
    set_req(0, 2); set_req(1, 3);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1);
      c0 += int'(mst_gnt_o[0]);
      c1 += int'(mst_gnt_o[1]);
    end
    check("t2_m0_cnt", 64'(c0), 64'd0);
    check("t2_m1_cnt", 64'(c1), 64'd3);
    slv_busy_i = '0;
    cyc(1'b1);
    check("t2_m0_after_busy", mst_gnt_o, 2'b01);
    nxt_sid[0] = '0; nxt_sid[1] = '0;
    set_req(0, 0); set_req(1, 0);
    repeat (3) cyc(1'b1);

    // Outstanding cap on slave 3: two issues, then the third waits for a response.
    nxt_sid[0] = 2'd3;
    set_req(0, 3);
    c0 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0);
      c0 += int'(mst_gnt_o[0]);
    end
    check("t3_issued", 64'(c0), 64'd2);
    check("t3_held", mst_gnt_o, 2'b00);
    slv_rsp_vld_i[2] = 1'b1;
    cyc(1'b0);
    check("t3_rsp_cycle", mst_gnt_o, 2'b00);
    nxt_sid[0] = '0;
    cyc(1'b0);
    check("t3_gnt_after_rsp", mst_gnt_o, 2'b01);
    slv_rsp_vld_i[2] = 1'b1;
    cyc(1'b0);
    slv_rsp_vld_i[2] = 1'b1;
    cyc(1'b0);
    check("t3_drained_no_err", err_rsp_o, 1'b0);

    // Issue and response in the same cycle leave the count at 1, shown by the error timing.
    set_req(0, 1);
    cyc(1'b0);
    check("t4_first_gnt", mst_gnt_o, 2'b01);
    cyc(1'b0);
    set_req(0, 1);
    slv_rsp_vld_i[0] = 1'b1;
    cyc(1'b0);
    check("t4_gnt_with_rsp", mst_gnt_o, 2'b01);
    slv_rsp_vld_i[0] = 1'b1;
    cyc(1'b0);
    check("t4_rsp_at_one", err_rsp_o, 1'b0);
    slv_rsp_vld_i[0] = 1'b1;
    cyc(1'b0);
    check("t4_rsp_at_zero", err_rsp_o, 1'b1);
    repeat (2) cyc(1'b0);
    check("t4_err_sticky", err_rsp_o, 1'b1);

    // Illegal SID on the two-slave instance: m1 never granted, m0 unaffected.
    @(negedge clk_ir);
    sid2 = {2'd3, 2'd1};
    data2 = {32'hbeef_0001, 32'hcafe_0000};
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_ir);
      c0 += int'(gnt2[0]);
      c1 += int'(gnt2[1]);
      if (gnt2[0]) data2[DATA_W-1:0] = $urandom();
      rsp2 = {1'b0, gnt2[0]};
    end
    check("t5_m0_cnt", 64'(c0), 64'd4);
    check("t5_m1_cnt", 64'(c1), 64'd0);
    check("t5_err_sid", esid2, 1'b1);
    check("t5_err_rsp", ersp2, 1'b0);
    sid2 = '0;
    rsp2 = '0;

    // Randomized traffic; responses only go to slaves with requests in flight.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_ir);
      for (int m = 0; m < N_MST; m++)
        if (mst_gnt_o[m] || mst_sid_i[m*SID_W +: SID_W] == '0)
          set_req(m, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3)));
      slv_busy_i = ($urandom_range(0, 2) == 0) ? N_SLV'($urandom_range(0, 7)) : '0;
      for (int s = 0; s < N_SLV; s++)
        slv_rsp_vld_i[s] = (m_out[s] > 0) && ($urandom_range(0, 1) == 1);
    end
    set_req(0, 0); set_req(1, 0);
    slv_busy_i = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_ir);
      for (int s = 0; s < N_SLV; s++) slv_rsp_vld_i[s] = (m_out[s] > 0);
    end

    // Reset mid-burst, right after a grant to m0 has moved the pointer to m1.
    nxt_sid[0] = 2'd1; nxt_sid[1] = 2'd1;
    set_req(0, 1); set_req(1, 1);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cyc(1'b1);
      if (mst_gnt_o == 2'b01) found = 1'b1;
    end
    check("t6_pre_gnt_m0", 64'(found), 64'd1);
    #3 rst_il = 1'b0;
    #1;
    check("t6_async_gnt", mst_gnt_o, '0);
    check("t6_async_mid", slv_req_mid_o, '0);
    check("t6_async_data", slv_req_data_o, '0);
    check("t6_async_err_rsp", err_rsp_o, 1'b0);
    slv_rsp_vld_i = '0;
    @(negedge clk_ir);
    rst_il = 1'b1;
    cyc(1'b1);
    check("t6_first_gnt_m0", mst_gnt_o, 2'b01);
    check("t6_first_mid", slv_req_mid_o, 6'b00_00_01);
    nxt_sid[0] = '0; nxt_sid[1] = '0;
    cyc(1'b1);
    slv_rsp_vld_i[2] = 1'b1;
    cyc(1'b1);
    check("t6_stray_rsp_err", err_rsp_o, 1'b1);
    repeat (3) cyc(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
